// File: rtl/nv_nvdla_rt_cmac2cacc_pipe_pkg.sv
// nvdla_cmac_rt_pkg: shared defaults and width helper for the CMAC->CACC retiming pipe
package nvdla_cmac_rt_pkg;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_LANES = 8;
  localparam int DEF_RESULT_WIDTH = 19;
  localparam int DEF_PD_WIDTH = 9;
  function automatic int inflight_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/nv_nvdla_rt_cmac2cacc_pipe_if.sv
// nv_nvdla_rt_cmac2cacc_pipe_if: one MAC partial-sum beat (valid, lane mask, mode, sideband, lane data)
interface nv_nvdla_rt_cmac2cacc_pipe_if
  import nvdla_cmac_rt_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int PD_WIDTH = DEF_PD_WIDTH
);
  logic pvld;
  logic [LANES-1:0] mask;
  logic mode;
  logic [PD_WIDTH-1:0] pd;
  logic [LANES*RESULT_WIDTH-1:0] data;
  modport master(output pvld, mask, mode, pd, data);
  modport slave(input pvld, mask, mode, pd, data);
endinterface

// File: rtl/nv_nvdla_rt_cmac2cacc_pipe_stage.sv
// nv_nvdla_rt_pipe_stage: one retiming stage with valid-gated payload and per-lane data enables
module nv_nvdla_rt_pipe_stage
  import nvdla_cmac_rt_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int PD_WIDTH = DEF_PD_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_pvld,
  input  logic [LANES-1:0] src_mask,
  input  logic src_mode,
  input  logic [PD_WIDTH-1:0] src_pd,
  input  logic [LANES*RESULT_WIDTH-1:0] src_data,
  output logic dst_pvld,
  output logic [LANES-1:0] dst_mask,
  output logic dst_mode,
  output logic [PD_WIDTH-1:0] dst_pd,
  output logic [LANES*RESULT_WIDTH-1:0] dst_data
);
  // unmasked lanes hold their last value so idle lanes do not toggle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dst_pvld <= 1'b0;
      dst_mask <= '0;
      dst_mode <= 1'b0;
      dst_pd <= '0;
      dst_data <= '0;
    end else begin
      dst_pvld <= src_pvld;
      dst_mask <= src_mask & {LANES{src_pvld}};
      if (src_pvld) begin
        dst_mode <= src_mode;
        dst_pd <= src_pd;
      end
      for (int k = 0; k < LANES; k++)
        if (src_pvld && src_mask[k])
          dst_data[k*RESULT_WIDTH +: RESULT_WIDTH] <= src_data[k*RESULT_WIDTH +: RESULT_WIDTH];
    end
endmodule

// File: rtl/nv_nvdla_rt_cmac2cacc_pipe.sv
// nv_nvdla_rt_cmac2cacc_pipe: LATENCY-deep CMAC->CACC retiming pipe with occupancy, idle, beat count and mask-error status
module nv_nvdla_rt_cmac2cacc_pipe
  import nvdla_cmac_rt_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int LANES = DEF_LANES,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int PD_WIDTH = DEF_PD_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  nv_nvdla_rt_cmac2cacc_pipe_if.slave mac2accu_src,
  nv_nvdla_rt_cmac2cacc_pipe_if.master mac2accu_dst,
  input  logic rt_cnt_clr,
  output logic [inflight_width(LATENCY)-1:0] rt_inflight,
  output logic rt_idle,
  output logic [CNT_WIDTH-1:0] rt_beat_cnt,
  output logic rt_mask_err
);
  localparam int IW = inflight_width(LATENCY);
  localparam int DW = LANES * RESULT_WIDTH;
  logic pvld [LATENCY+1];
  logic mode [LATENCY+1];
  logic [LANES-1:0] mask [LATENCY+1];
  logic [PD_WIDTH-1:0] pd [LATENCY+1];
  logic [DW-1:0] data [LATENCY+1];
  assign pvld[0] = mac2accu_src.pvld;
  assign mask[0] = mac2accu_src.mask;
  assign mode[0] = mac2accu_src.mode;
  assign pd[0] = mac2accu_src.pd;
  assign data[0] = mac2accu_src.data;
  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    nv_nvdla_rt_pipe_stage #(
      .LANES(LANES),
      .RESULT_WIDTH(RESULT_WIDTH),
      .PD_WIDTH(PD_WIDTH)
    ) u_stage (
      .clk(nvdla_core_clk),
      .rst_n(nvdla_core_rstn),
      .src_pvld(pvld[s]),
      .src_mask(mask[s]),
      .src_mode(mode[s]),
      .src_pd(pd[s]),
      .src_data(data[s]),
      .dst_pvld(pvld[s+1]),
      .dst_mask(mask[s+1]),
      .dst_mode(mode[s+1]),
      .dst_pd(pd[s+1]),
      .dst_data(data[s+1])
    );
  end
  // registered stages already qualify the mask; this only matters for the bypass case
  assign mac2accu_dst.pvld = pvld[LATENCY];
  assign mac2accu_dst.mask = mask[LATENCY] & {LANES{pvld[LATENCY]}};
  assign mac2accu_dst.mode = mode[LATENCY];
  assign mac2accu_dst.pd = pd[LATENCY];
  assign mac2accu_dst.data = data[LATENCY];
  assign rt_idle = (rt_inflight == '0) & ~pvld[0];
  // in bypass src and dst valid are the same wire, so the occupancy stays 0
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      rt_inflight <= '0;
      rt_beat_cnt <= '0;
      rt_mask_err <= 1'b0;
    end else begin
      rt_inflight <= rt_inflight + IW'(pvld[0]) - IW'(pvld[LATENCY]);
      rt_beat_cnt <= (rt_cnt_clr ? '0 : rt_beat_cnt) + CNT_WIDTH'(pvld[LATENCY]);
      rt_mask_err <= (rt_mask_err & ~rt_cnt_clr) | (~pvld[0] & (|mask[0]));
    end
endmodule

// File: tb/tb_nv_nvdla_rt_cmac2cacc_pipe.sv
// tb_nv_nvdla_rt_cmac2cacc_pipe: directed checks on LATENCY 0/2/3/4 instances sharing one source
module tb_nv_nvdla_rt_cmac2cacc_pipe;
  localparam int RW = 19;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;
  nv_nvdla_rt_cmac2cacc_pipe_if src ();
  nv_nvdla_rt_cmac2cacc_pipe_if q0 ();
  nv_nvdla_rt_cmac2cacc_pipe_if q2 ();
  nv_nvdla_rt_cmac2cacc_pipe_if q3 ();
  nv_nvdla_rt_cmac2cacc_pipe_if q4 ();
  logic [0:0] inf0;
  logic [1:0] inf2, inf3;
  logic [2:0] inf4;
  logic idle0, idle2, idle3, idle4, err0, err2, err3, err4;
  logic [15:0] cnt0, cnt3, cnt4;
  logic [3:0] cnt2;
  nv_nvdla_rt_cmac2cacc_pipe #(.LATENCY(0)) d0 (.nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .mac2accu_src(src), .mac2accu_dst(q0), .rt_cnt_clr(clr), .rt_inflight(inf0), .rt_idle(idle0),
    .rt_beat_cnt(cnt0), .rt_mask_err(err0));
  nv_nvdla_rt_cmac2cacc_pipe #(.LATENCY(2), .CNT_WIDTH(4)) d2 (.nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .mac2accu_src(src), .mac2accu_dst(q2), .rt_cnt_clr(clr), .rt_inflight(inf2), .rt_idle(idle2),
    .rt_beat_cnt(cnt2), .rt_mask_err(err2));
  nv_nvdla_rt_cmac2cacc_pipe #(.LATENCY(3)) d3 (.nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .mac2accu_src(src), .mac2accu_dst(q3), .rt_cnt_clr(clr), .rt_inflight(inf3), .rt_idle(idle3),
    .rt_beat_cnt(cnt3), .rt_mask_err(err3));
  nv_nvdla_rt_cmac2cacc_pipe #(.LATENCY(4)) d4 (.nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .mac2accu_src(src), .mac2accu_dst(q4), .rt_cnt_clr(clr), .rt_inflight(inf4), .rt_idle(idle4),
    .rt_beat_cnt(cnt4), .rt_mask_err(err4));
  int pass_n = 0;
  int total_n = 0;
  logic [151:0] exp_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_src();
    src.pvld = 1'b0;
    src.mask = '0;
    src.mode = 1'b0;
    src.pd = '0;
    src.data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    idle_src();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    total_n++; if ({q2.pvld, q2.mask, q2.mode, q2.pd, q2.data} !== '0) $display("FAIL reset_dst2 got %h want 0", {q2.pvld, q2.mask, q2.mode, q2.pd, q2.data}); else pass_n++;
    total_n++; if ({q3.pvld, q3.mask, q3.mode, q3.pd, q3.data} !== '0) $display("FAIL reset_dst3 got %h want 0", {q3.pvld, q3.mask, q3.mode, q3.pd, q3.data}); else pass_n++;
    total_n++; if ({q4.pvld, q4.mask, q4.mode, q4.pd, q4.data} !== '0) $display("FAIL reset_dst4 got %h want 0", {q4.pvld, q4.mask, q4.mode, q4.pd, q4.data}); else pass_n++;
    total_n++; if ({inf0, inf2, inf3, inf4} !== '0) $display("FAIL reset_inflight got %h want 0", {inf0, inf2, inf3, inf4}); else pass_n++;
    total_n++; if ({idle0, idle2, idle3, idle4} !== 4'hF) $display("FAIL reset_idle got %h want f", {idle0, idle2, idle3, idle4}); else pass_n++;
    total_n++; if ({cnt2, cnt3, cnt4, err2, err3, err4} !== '0) $display("FAIL reset_status got %h want 0", {cnt2, cnt3, cnt4, err2, err3, err4}); else pass_n++;
  endtask

  task automatic test_single_beat();
    src.pvld = 1'b1;
    src.mask = 8'hFF;
    for (int k = 0; k < 8; k++) src.data[k*RW +: RW] = 19'h10000 + 19'(k);
    exp_data = src.data;
    tick();
    idle_src();
    repeat (3) tick();
    src.pvld = 1'b1;
    src.mask = 8'h05;
    src.mode = 1'b1;
    src.pd = 9'h1A3;
    for (int k = 0; k < 8; k++) src.data[k*RW +: RW] = 19'h55555;
    src.data[0 +: RW] = 19'h12345;
    src.data[2*RW +: RW] = 19'h7FFFF;
    exp_data[0 +: RW] = 19'h12345;
    exp_data[2*RW +: RW] = 19'h7FFFF;
    #1;
    total_n++; if ({q0.pvld, q0.mask, q0.mode, q0.pd, q0.data} !== {1'b1, 8'h05, 1'b1, 9'h1A3, src.data}) $display("FAIL bypass_beat got %h want %h", {q0.pvld, q0.mask, q0.mode, q0.pd, q0.data}, {1'b1, 8'h05, 1'b1, 9'h1A3, src.data}); else pass_n++;
    total_n++; if (idle2 !== 1'b0) $display("FAIL idle_arriving got %b want 0", idle2); else pass_n++;
    tick();
    total_n++; if ({inf2, q2.pvld} !== {2'd1, 1'b0}) $display("FAIL beat_cycle1 got %h want 2", {inf2, q2.pvld}); else pass_n++;
    idle_src();
    tick();
    total_n++; if (inf2 !== 2'd1) $display("FAIL inflight_cycle2 got %0d want 1", inf2); else pass_n++;
    total_n++; if ({q2.pvld, q2.mask, q2.mode, q2.pd, q2.data} !== {1'b1, 8'h05, 1'b1, 9'h1A3, exp_data}) $display("FAIL beat_dst got %h want %h", {q2.pvld, q2.mask, q2.mode, q2.pd, q2.data}, {1'b1, 8'h05, 1'b1, 9'h1A3, exp_data}); else pass_n++;
    tick();
    total_n++; if ({inf2, idle2} !== {2'd0, 1'b1}) $display("FAIL drained got %h want 1", {inf2, idle2}); else pass_n++;
    total_n++; if ({q2.pvld, q2.mask, q2.mode, q2.pd, q2.data} !== {1'b0, 8'h00, 1'b1, 9'h1A3, exp_data}) $display("FAIL hold_after_beat got %h want %h", {q2.pvld, q2.mask, q2.mode, q2.pd, q2.data}, {1'b0, 8'h00, 1'b1, 9'h1A3, exp_data}); else pass_n++;
  endtask

  task automatic test_mask_err();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_n++; if (err2 !== 1'b0) $display("FAIL err_cleared_start got %b want 0", err2); else pass_n++;
    src.mask = 8'hFF;
    src.data = 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
    #1;
    total_n++; if ({q0.pvld, q0.mask} !== 9'h0) $display("FAIL bypass_mask_qual got %h want 0", {q0.pvld, q0.mask}); else pass_n++;
    tick();
    total_n++; if (err2 !== 1'b1) $display("FAIL err_set got %b want 1", err2); else pass_n++;
    idle_src();
    repeat (3) tick();
    total_n++; if ({q2.pvld, q2.mask, q2.data} !== {1'b0, 8'h00, exp_data}) $display("FAIL invalid_no_load got %h want %h", {q2.pvld, q2.mask, q2.data}, {1'b0, 8'h00, exp_data}); else pass_n++;
    total_n++; if (err2 !== 1'b1) $display("FAIL err_sticky got %b want 1", err2); else pass_n++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_n++; if (err2 !== 1'b0) $display("FAIL err_clr got %b want 0", err2); else pass_n++;
    clr = 1'b1;
    src.mask = 8'h10;
    tick();
    clr = 1'b0;
    idle_src();
    total_n++; if (err2 !== 1'b1) $display("FAIL err_set_wins got %b want 1", err2); else pass_n++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_n++; if (err2 !== 1'b0) $display("FAIL err_clr2 got %b want 0", err2); else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bm [100];
    logic [8:0] bp [100];
    logic bo [100];
    logic [151:0] bd [100];
    logic [151:0] held;
    int j;
    held = exp_data;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bm[i] = 8'($urandom);
      bp[i] = 9'($urandom);
      bo[i] = 1'($urandom);
      bd[i] = 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
    end
    for (int c = 0; c < 102; c++) begin
      if (c < 100) begin
        src.pvld = 1'b1;
        src.mask = bm[c];
        src.mode = bo[c];
        src.pd = bp[c];
        src.data = bd[c];
      end else idle_src();
      tick();
      if (c >= 2) begin
        j = c - 2;
        for (int k = 0; k < 8; k++) if (bm[j][k]) held[k*RW +: RW] = bd[j][k*RW +: RW];
        total_n++; if ({q3.pvld, q3.mask, q3.mode, q3.pd, q3.data} !== {1'b1, bm[j], bo[j], bp[j], held}) $display("FAIL b2b_beat%0d got %h want %h", j, {q3.pvld, q3.mask, q3.mode, q3.pd, q3.data}, {1'b1, bm[j], bo[j], bp[j], held}); else pass_n++;
      end
      if (c == 50) begin
        total_n++; if ({inf3, idle3, inf0} !== {2'd3, 1'b0, 1'b0}) $display("FAIL b2b_steady got %h want c", {inf3, idle3, inf0}); else pass_n++;
      end
    end
    tick();
    total_n++; if ({q3.pvld, inf3, idle3} !== {1'b0, 2'd0, 1'b1}) $display("FAIL b2b_drained got %h want 1", {q3.pvld, inf3, idle3}); else pass_n++;
    total_n++; if (cnt3 !== 16'd100) $display("FAIL b2b_count got %0d want 100", cnt3); else pass_n++;
  endtask

  task automatic test_cnt_wrap();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_n++; if (cnt2 !== 4'd0) $display("FAIL cnt_clr got %0d want 0", cnt2); else pass_n++;
    src.pvld = 1'b1;
    src.mask = 8'h01;
    repeat (15) tick();
    idle_src();
    repeat (3) tick();
    total_n++; if (cnt2 !== 4'd15) $display("FAIL cnt_15 got %0d want 15", cnt2); else pass_n++;
    src.pvld = 1'b1;
    tick();
    idle_src();
    repeat (3) tick();
    total_n++; if (cnt2 !== 4'd0) $display("FAIL cnt_wrap got %0d want 0", cnt2); else pass_n++;
    src.pvld = 1'b1;
    tick();
    idle_src();
    tick();
    total_n++; if (q2.pvld !== 1'b1) $display("FAIL cnt_align got %b want 1", q2.pvld); else pass_n++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_n++; if (cnt2 !== 4'd1) $display("FAIL cnt_clr_with_beat got %0d want 1", cnt2); else pass_n++;
    tick();
    total_n++; if (cnt2 !== 4'd1) $display("FAIL cnt_after got %0d want 1", cnt2); else pass_n++;
  endtask

  task automatic test_reset_midstream();
    logic seen;
    src.pvld = 1'b1;
    src.mask = 8'h03;
    tick();
    tick();
    idle_src();
    total_n++; if (inf4 !== 3'd2) $display("FAIL mid_inflight got %0d want 2", inf4); else pass_n++;
    #2 rst_n = 1'b0;
    #1;
    total_n++; if ({inf4, idle4, q4.pvld} !== {3'd0, 1'b1, 1'b0}) $display("FAIL mid_reset_now got %h want 2", {inf4, idle4, q4.pvld}); else pass_n++;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= q4.pvld;
    end
    total_n++; if (seen !== 1'b0) $display("FAIL mid_no_beat got %b want 0", seen); else pass_n++;
    total_n++; if ({cnt4, inf4} !== '0) $display("FAIL mid_status got %h want 0", {cnt4, inf4}); else pass_n++;
  endtask

  initial begin
    idle_src();
    test_reset();
    test_single_beat();
    test_mask_err();
    test_back_to_back();
    test_cnt_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
